// File: rtl/led_shift_top.sv
`default_nettype none
// ============================================================================
// Module      : led_shift_top (with led_shift_prescaler, led_shift_reg)
// Description : LED rotator. A gated prescaler with four selectable speeds
//               emits a one-cycle tick; each tick rotates a one-hot pattern
//               left by one. A colour switch steers the pattern to the blue
//               or green LED outputs.
// Ports       : clock    - single clock, rising edge
//               i_reset  - asynchronous reset, active low
//               i_sw     - [0] enable, [2:1] speed, [3] colour (1 = green)
//               o_led    - current rotating pattern
//               o_led_b  - blue LED drive
//               o_led_g  - green LED drive
// Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// Prescaler: free-running counter with a speed-dependent wrap limit.
// ----------------------------------------------------------------------------
module led_shift_prescaler #(
    parameter int NB_COUNTER = 16
) (
    input  logic       clock,
    input  logic       i_reset,
    input  logic       i_enable,
    input  logic [1:0] i_speed,
    output logic       o_tick
);
    localparam logic [NB_COUNTER-1:0] c_ONE    = {{(NB_COUNTER-1){1'b0}}, 1'b1};
    localparam logic [NB_COUNTER-1:0] c_LIM_R0 = (c_ONE << (NB_COUNTER-10)) - c_ONE;
    localparam logic [NB_COUNTER-1:0] c_LIM_R1 = (c_ONE << (NB_COUNTER-11)) - c_ONE;
    localparam logic [NB_COUNTER-1:0] c_LIM_R2 = (c_ONE << (NB_COUNTER-12)) - c_ONE;
    localparam logic [NB_COUNTER-1:0] c_LIM_R3 = (c_ONE << (NB_COUNTER-13)) - c_ONE;

    logic [NB_COUNTER-1:0] r_count;
    logic [NB_COUNTER-1:0] w_limit;
    logic                  w_tick;

    always_comb begin
        w_limit = c_LIM_R0;
        case (i_speed)
            2'b00:   w_limit = c_LIM_R0;
            2'b01:   w_limit = c_LIM_R1;
            2'b10:   w_limit = c_LIM_R2;
            default: w_limit = c_LIM_R3;
        endcase
    end

    // ">=" rather than "==" so a switch to a faster speed while the count is
    // already above the new limit wraps immediately instead of overflowing.
    assign w_tick = i_enable && (r_count >= w_limit);
    assign o_tick = w_tick;

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_count <= '0;
        end else if (w_tick) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + c_ONE;
        end
    end
endmodule

// ----------------------------------------------------------------------------
// Shift register: one-hot pattern rotated left on each tick.
// ----------------------------------------------------------------------------
module led_shift_reg #(
    parameter int NB_LEDS = 4
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic               i_tick,
    output logic [NB_LEDS-1:0] o_led
);
    localparam logic [NB_LEDS-1:0] c_LED_INIT = {{(NB_LEDS-1){1'b0}}, 1'b1};

    logic [NB_LEDS-1:0] r_led;

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_led <= c_LED_INIT;
        end else if (i_tick) begin
            r_led <= {r_led[NB_LEDS-2:0], r_led[NB_LEDS-1]};
        end
    end

    assign o_led = r_led;
endmodule

// ----------------------------------------------------------------------------
// Top: prescaler + shift register + colour mux.
// ----------------------------------------------------------------------------
module led_shift_top #(
    parameter int NB_LEDS    = 4,
    parameter int NB_COUNTER = 16,
    parameter int NB_SW      = 4
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic [NB_SW-1:0]   i_sw,
    output logic [NB_LEDS-1:0] o_led,
    output logic [NB_LEDS-1:0] o_led_b,
    output logic [NB_LEDS-1:0] o_led_g
);
    logic               w_tick;
    logic [NB_LEDS-1:0] w_led;

    led_shift_prescaler #(
        .NB_COUNTER (NB_COUNTER)
    ) u_prescaler (
        .clock    (clock),
        .i_reset  (i_reset),
        .i_enable (i_sw[0]),
        .i_speed  (i_sw[2:1]),
        .o_tick   (w_tick)
    );

    led_shift_reg #(
        .NB_LEDS (NB_LEDS)
    ) u_shift (
        .clock   (clock),
        .i_reset (i_reset),
        .i_tick  (w_tick),
        .o_led   (w_led)
    );

    assign o_led   = w_led;
    assign o_led_b = i_sw[3] ? '0 : w_led;
    assign o_led_g = i_sw[3] ? w_led : '0;
endmodule

`default_nettype wire

// File: tb/tb_led_shift_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_shift_top
// Description : Self-checking bench for led_shift_top. A behavioural model
//               (count value + index of the lit LED) is checked against the
//               DUT on every falling edge; directed sections pin the model
//               with hand-computed literal patterns.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_shift_top;
    localparam int NB_LEDS    = 4;
    localparam int NB_COUNTER = 16;
    localparam int NB_SW      = 4;

    logic               clock   = 1'b0;
    logic               i_reset = 1'b0;
    logic [NB_SW-1:0]   i_sw    = '0;
    logic [NB_LEDS-1:0] o_led;
    logic [NB_LEDS-1:0] o_led_b;
    logic [NB_LEDS-1:0] o_led_g;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    led_shift_top #(
        .NB_LEDS    (NB_LEDS),
        .NB_COUNTER (NB_COUNTER),
        .NB_SW      (NB_SW)
    ) dut (
        .clock   (clock),
        .i_reset (i_reset),
        .i_sw    (i_sw),
        .o_led   (o_led),
        .o_led_b (o_led_b),
        .o_led_g (o_led_g)
    );

    always #5 clock = ~clock;

    // ---------------- behavioural model ----------------
    int m_cnt = 0;   // prescaler count
    int m_pos = 0;   // index of the lit LED

    function automatic int limit_of(input int s);
        return (1 << (NB_COUNTER - 10 - s)) - 1;
    endfunction

    function automatic logic [NB_LEDS-1:0] m_led();
        return NB_LEDS'(1 << m_pos);
    endfunction

    always @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            m_cnt = 0;
            m_pos = 0;
        end else if (i_sw[0]) begin
            if (m_cnt >= limit_of(int'(i_sw[2:1]))) begin
                m_cnt = 0;
                m_pos = (m_pos + 1) % NB_LEDS;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        if (chk_en) begin
            chk("cyc_led", 32'(o_led), 32'(m_led()));
            chk("cyc_led_b", 32'(o_led_b), i_sw[3] ? 32'd0 : 32'(m_led()));
            chk("cyc_led_g", 32'(o_led_g), i_sw[3] ? 32'(m_led()) : 32'd0);
        end
    end

    // wait n rising edges, then step 1 ns past the last one
    task automatic edges(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // hold reset across one edge, release 1 ns after the following edge
    task automatic sync_reset(input logic [NB_SW-1:0] sw_after);
        i_reset = 1'b0;
        edges(1);
        i_reset = 1'b1;
        i_sw    = sw_after;
    endtask

    logic [NB_LEDS-1:0] exp_seq [5];
    logic [NB_LEDS-1:0] saved;
    int                 n;
    int                 spd [3];
    int                 spd_exp [3];

    initial begin
        exp_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        spd     = '{3, 1, 2};
        spd_exp = '{8, 32, 16};

        // ---- reset state ----
        #22;
        chk("rst_led", 32'(o_led), 32'h1);
        chk("rst_led_b", 32'(o_led_b), 32'h1);
        chk("rst_led_g", 32'(o_led_g), 32'h0);
        i_sw = 4'b1000;
        #1;
        chk("rst_led_g_green", 32'(o_led_g), 32'h1);
        chk("rst_led_b_green", 32'(o_led_b), 32'h0);
        chk_en = 1'b1;

        // ---- rotation at R0, green ----
        edges(0);
        @(posedge clock); #1;
        i_reset = 1'b1;
        i_sw    = 4'b1001;
        edges(63);
        chk("r0_pre", 32'(o_led), 32'h1);
        edges(1);
        chk("r0_win0", 32'(o_led), 32'(exp_seq[0]));
        chk("r0_win0_g", 32'(o_led_g), 32'(exp_seq[0]));
        for (int w = 1; w < 5; w++) begin
            edges(63);
            chk("r0_hold", 32'(o_led), 32'(exp_seq[w-1]));
            edges(1);
            chk("r0_win", 32'(o_led), 32'(exp_seq[w]));
        end

        // ---- colour switching at random delays ----
        i_sw = 4'b0111;
        for (int k = 0; k < 5; k++) begin
            #($urandom_range(1, 3));
            i_sw[3] = 1'b0;
            #1;
            chk("col_blue_b", 32'(o_led_b), 32'(m_led()));
            chk("col_blue_g", 32'(o_led_g), 32'h0);
            i_sw[3] = 1'b1;
            #1;
            chk("col_green_g", 32'(o_led_g), 32'(m_led()));
            chk("col_green_b", 32'(o_led_b), 32'h0);
            edges($urandom_range(1, 20));
        end

        // ---- enable gating ----
        for (int k = 0; k < 5; k++) begin
            edges($urandom_range(3, 25));
            saved   = m_led();
            i_sw[0] = 1'b0;
            #($urandom_range(100, 2000));
            chk("gate_hold", 32'(o_led), 32'(saved));
            @(posedge clock); #1;
            i_sw[0] = 1'b1;
        end

        // ---- speed R3/R1/R2 first-rotation latency ----
        for (int k = 0; k < 3; k++) begin
            sync_reset({2'b00, 2'(spd[k]), 1'b0} >> 1);
            i_sw = {1'b0, 2'(spd[k]), 1'b0};
            edges(1);
            i_sw[0] = 1'b1;
            n = 0;
            while (n < 200) begin
                edges(1);
                n++;
                if (o_led != 4'b0001) break;
            end
            chk("speed_latency", 32'(n), 32'(spd_exp[k]));
            chk("speed_led", 32'(o_led), 32'h2);
        end

        // ---- speed switch mid-count: R0 count 40 -> R3 ----
        sync_reset(4'b0001);
        edges(40);
        chk("mid_pre", 32'(o_led), 32'h1);
        i_sw = 4'b0111;
        edges(1);
        chk("mid_wrap", 32'(o_led), 32'h2);
        edges(7);
        chk("mid_hold", 32'(o_led), 32'h2);
        edges(1);
        chk("mid_r3_period", 32'(o_led), 32'h4);

        // ---- async reset at random instants ----
        for (int k = 0; k < 5; k++) begin
            i_sw = 4'b0111;
            edges($urandom_range(5, 40));
            #($urandom_range(0, 3));
            i_reset = 1'b0;
            #10;
            chk("async_rst", 32'(o_led), 32'h1);
            @(posedge clock); #1;
            i_reset = 1'b1;
        end

        // ---- randomized run ----
        for (int c = 0; c < 3000; c++) begin
            edges(1);
            if ($urandom_range(0, 15) == 0) begin
                i_sw = 4'($urandom);
                if ($urandom_range(0, 3) != 0) i_sw[0] = 1'b1;
            end
            if ($urandom_range(0, 149) == 0) begin
                #($urandom_range(0, 1));
                i_reset = 1'b0;
                #2;
                i_reset = 1'b1;
            end
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

`default_nettype wire
